// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: exception codes,
// PC defaults and the bubble-kind decode used by every stage boundary.
package pipe_pkg;

  localparam int          EXC_W_DFLT      = 5;
  localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_0000;
  localparam logic [31:0] HANDLER_PC_DFLT = 32'h0000_4180;

  // CP0 Cause.ExcCode values; INT shares code 0 with "no exception"
  localparam logic [EXC_W_DFLT-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W_DFLT-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W_DFLT-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W_DFLT-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W_DFLT-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W_DFLT-1:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    BUB_NONE,
    BUB_REQ,
    BUB_FLUSH,
    BUB_STALL
  } bubble_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bus: upstream stage drives the master side, the stage
// register sits on the slave side.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 8
);
  logic              en, req, flush, stall, bd_in;
  logic [31:0]       flush_pc, pc_in, instr_in;
  logic [DATA_W-1:0] data_in;
  logic [EXC_W-1:0]  exc_in, exc_local;

  logic [31:0]       pc_out, instr_out;
  logic [DATA_W-1:0] data_out;
  logic [EXC_W-1:0]  exc_out;
  logic              bd_out, valid_out;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output en, req, flush, flush_pc, stall, pc_in, instr_in, data_in,
           exc_in, exc_local, bd_in,
    input  pc_out, instr_out, data_out, exc_out, bd_out, valid_out, stall_cnt
  );

  modport slave (
    input  en, req, flush, flush_pc, stall, pc_in, instr_in, data_in,
           exc_in, exc_local, bd_in,
    output pc_out, instr_out, data_out, exc_out, bd_out, valid_out, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset || clr)           cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: capture, exception/redirect flush, stall
// bubble and hold, with exception merge and a consecutive-stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W     = 96,
  parameter int          EXC_W      = EXC_W_DFLT,
  parameter logic [31:0] RESET_PC   = RESET_PC_DFLT,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DFLT,
  parameter int          CNT_W      = 8
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  bubble_e kind;

  always_comb begin
    kind = BUB_NONE;
    if      (bus.req)   kind = BUB_REQ;
    else if (bus.flush) kind = BUB_FLUSH;
    else if (bus.stall) kind = BUB_STALL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pc_out    <= RESET_PC;
      bus.instr_out <= '0;
      bus.data_out  <= '0;
      bus.exc_out   <= '0;
      bus.bd_out    <= 1'b0;
      bus.valid_out <= 1'b0;
    end else begin
      case (kind)
        BUB_REQ, BUB_FLUSH: begin
          bus.pc_out    <= (kind == BUB_REQ) ? HANDLER_PC : bus.flush_pc;
          bus.instr_out <= '0;
          bus.data_out  <= '0;
          bus.exc_out   <= '0;
          bus.bd_out    <= 1'b0;
          bus.valid_out <= 1'b0;
        end
        BUB_STALL: begin
          // bubble keeps PC/BD so an interrupt taken on it reports the right EPC
          bus.pc_out    <= bus.pc_in;
          bus.bd_out    <= bus.bd_in;
          bus.instr_out <= '0;
          bus.data_out  <= '0;
          bus.exc_out   <= '0;
          bus.valid_out <= 1'b0;
        end
        default: begin
          if (bus.en) begin
            bus.pc_out    <= bus.pc_in;
            bus.instr_out <= bus.instr_in;
            bus.data_out  <= bus.data_in;
            bus.exc_out   <= (bus.exc_in != '0) ? bus.exc_in : bus.exc_local;
            bus.bd_out    <= bus.bd_in;
            bus.valid_out <= 1'b1;
          end
        end
      endcase
    end
  end

  logic cnt_inc, cnt_clr;
  assign cnt_inc = (kind == BUB_STALL);
  assign cnt_clr = (kind == BUB_REQ) || (kind == BUB_FLUSH) ||
                   ((kind == BUB_NONE) && bus.en);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (bus.stall_cnt)
  );
endmodule
